cp_null_insert: RTL

- OFDM transmit framer; the transmit-side counterpart of the receive null-symbol/cyclic-prefix detector.
- Accepts time-domain symbols from the IFFT and buffers them in a ping-pong RAM.
- Emits frames of the form: null symbol (zero samples), then N data symbols, each preceded by its cyclic prefix (CP).
- Output is paced by the interpolator/DAC sample-clock enable.

---
 rtl/cp_null_pkg.sv | 32 +++
 rtl/dpram_2kx32.sv | 27 ++
 rtl/cp_null_insert.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cp_null_pkg.sv
// Shared types and constants for the OFDM transmit framer (null symbol + cyclic prefix insertion).
// Defines the read-FSM states, register reset defaults and configuration field positions.
package cp_null_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NULL = 2'd1,
        CP   = 2'd2,
        BODY = 2'd3
    } state_t;

    // reg0: {cplen-1, fftsize}
    localparam int FFT_LSB  = 0;
    localparam int FFT_MSB  = 9;
    localparam int CPM1_LSB = 10;
    localparam int CPM1_MSB = 15;

    // reg1: {nsym, nullen}
    localparam int NULL_LSB = 0;
    localparam int NULL_MSB = 8;
    localparam int NSYM_LSB = 9;
    localparam int NSYM_MSB = 15;

    localparam logic [9:0] FFT_RST  = 10'd256;
    localparam logic [5:0] CPM1_RST = 6'd63;
    localparam logic [8:0] NULL_RST = 9'd320;
    localparam logic [6:0] NSYM_RST = 7'd76;

    localparam logic [15:0] REG0_RST = {CPM1_RST, FFT_RST};
    localparam logic [15:0] REG1_RST = {NSYM_RST, NULL_RST};

endpackage

// File: rtl/dpram_2kx32.sv
// Simple dual-port RAM, one write port and one synchronous read port (1-cycle read latency).
// No backpressure; read data holds its value when re is low.
module dpram_2kx32 #(
    parameter int AW = 11,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic          re,
    input  logic [AW-1:0] ra,
    output logic [DW-1:0] rd
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wa] <= wd;
        end
        if (re) begin
            rd <= mem[ra];
        end
    end

endmodule

// File: rtl/cp_null_insert.sv
// OFDM transmit framer: ping-pong buffers IFFT symbols, emits null symbol then CP+body per symbol.
// Outputs lag sce by one cycle; irdy drops while the write bank is still full.
module cp_null_insert
    import cp_null_pkg::*;
#(
    parameter int DW = 16,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [15:0]   cin,
    input  logic [1:0]    cwe,
    input  logic [DW-1:0] id,
    input  logic [DW-1:0] qd,
    input  logic          iv,
    output logic          irdy,
    input  logic          start,
    input  logic          sce,
    output logic [DW-1:0] io,
    output logic [DW-1:0] qo,
    output logic          ov,
    output logic          sof,
    output logic          sos,
    output logic          busy,
    output logic          err
);

    localparam logic [AW-1:0] ONE = AW'(1);

    logic [15:0]   reg0;
    logic [15:0]   reg1;
    logic [AW-1:0] fft_live;

    logic [AW-1:0] w_fft;
    logic [5:0]    w_cpm1;
    logic [8:0]    w_null;
    logic [6:0]    w_nsym;
    logic [AW-1:0] cp_start;
    logic [AW-1:0] fft_last;

    logic          wbank;
    logic [AW-1:0] waddr;
    logic [1:0]    full;
    logic [1:0]    full_n;
    logic          wr_en;
    logic          wr_fill;
    logic          flush;

    state_t        state;
    state_t        state_n;
    logic [8:0]    cnt;
    logic [8:0]    cnt_n;
    logic [AW-1:0] raddr;
    logic [AW-1:0] raddr_n;
    logic [6:0]    symcnt;
    logic [6:0]    symcnt_n;
    logic          rbank;
    logic          rbank_n;
    logic          nxt_ready;

    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          cp_go;
    logic          rel;
    logic          err_set;
    logic          latch;
    logic          sof_n;
    logic          sos_n;
    logic          sel;
    logic [2*DW-1:0] rdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg0 <= REG0_RST;
            reg1 <= REG1_RST;
        end else begin
            if (cwe[0]) begin
                reg0 <= cin;
            end
            if (cwe[1]) begin
                reg1 <= cin;
            end
        end
    end

    assign fft_live = AW'(reg0[FFT_MSB:FFT_LSB]);
    assign cp_start = w_fft - AW'(w_cpm1) - ONE;
    assign fft_last = w_fft - ONE;

    // Config writes flush the buffers only while idle; mid-frame they just stage the next frame.
    assign flush   = (|cwe) && (state == IDLE);
    assign irdy    = ~full[wbank];
    assign wr_en   = iv & irdy;
    assign wr_fill = wr_en && (waddr == fft_live - ONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            waddr <= '0;
            wbank <= 1'b0;
        end else if (flush) begin
            waddr <= '0;
            wbank <= 1'b0;
        end else if (wr_en) begin
            if (wr_fill) begin
                waddr <= '0;
                wbank <= ~wbank;
            end else begin
                waddr <= waddr + ONE;
            end
        end
    end

    always_comb begin
        full_n = full;
        if (rel) begin
            full_n[rbank] = 1'b0;
        end
        if (wr_fill) begin
            full_n[wbank] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full <= 2'b00;
        end else if (flush) begin
            full <= 2'b00;
        end else begin
            full <= full_n;
        end
    end

    // A bank being filled this very cycle counts as ready for the next symbol.
    assign nxt_ready = full[~rbank] | (wr_fill & (wbank == ~rbank));

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        raddr_n  = raddr;
        symcnt_n = symcnt;
        rbank_n  = rbank;
        rd_en    = 1'b0;
        rd_addr  = raddr;
        cp_go    = 1'b0;
        rel      = 1'b0;
        err_set  = 1'b0;
        latch    = 1'b0;
        sof_n    = 1'b0;
        sos_n    = 1'b0;
        if (sce) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sof_n    = 1'b1;
                        state_n  = NULL;
                        cnt_n    = '0;
                        symcnt_n = '0;
                        latch    = 1'b1;
                    end
                end
                NULL: begin
                    if (({1'b0, cnt} + 10'd1) < {1'b0, w_null}) begin
                        cnt_n = cnt + 9'd1;
                    end else if (full[rbank]) begin
                        cp_go   = 1'b1;
                        rd_addr = cp_start;
                    end
                end
                CP: begin
                    cp_go = 1'b1;
                end
                BODY: begin
                    rd_en = 1'b1;
                    if (raddr == fft_last) begin
                        rel      = 1'b1;
                        rbank_n  = ~rbank;
                        symcnt_n = symcnt + 7'd1;
                        raddr_n  = '0;
                        if (symcnt == w_nsym - 7'd1) begin
                            state_n = IDLE;
                        end else if (nxt_ready) begin
                            state_n = CP;
                            raddr_n = cp_start;
                        end else begin
                            err_set = 1'b1;
                            state_n = IDLE;
                        end
                    end else begin
                        raddr_n = raddr + ONE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
        // The first CP sample is emitted on the NULL exit cycle itself, so the null length is exact.
        if (cp_go) begin
            rd_en = 1'b1;
            sos_n = (rd_addr == cp_start);
            if (rd_addr == fft_last) begin
                state_n = BODY;
                raddr_n = '0;
            end else begin
                state_n = CP;
                raddr_n = rd_addr + ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            raddr  <= '0;
            symcnt <= '0;
            rbank  <= 1'b0;
            err    <= 1'b0;
            w_fft  <= AW'(FFT_RST);
            w_cpm1 <= CPM1_RST;
            w_null <= NULL_RST;
            w_nsym <= NSYM_RST;
            ov     <= 1'b0;
            sel    <= 1'b0;
            sof    <= 1'b0;
            sos    <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            raddr  <= raddr_n;
            symcnt <= symcnt_n;
            rbank  <= flush ? 1'b0 : rbank_n;
            if (flush) begin
                err <= 1'b0;
            end else if (err_set) begin
                err <= 1'b1;
            end
            if (latch) begin
                w_fft  <= AW'(reg0[FFT_MSB:FFT_LSB]);
                w_cpm1 <= reg0[CPM1_MSB:CPM1_LSB];
                w_null <= reg1[NULL_MSB:NULL_LSB];
                w_nsym <= reg1[NSYM_MSB:NSYM_LSB];
            end
            ov  <= sce;
            sel <= rd_en;
            sof <= sof_n;
            sos <= sos_n;
        end
    end

    assign busy = (state != IDLE);

    dpram_2kx32 #(
        .AW(AW + 1),
        .DW(2 * DW)
    ) u_ram (
        .clk (clk),
        .we  (wr_en),
        .wa  ({wbank, waddr}),
        .wd  ({id, qd}),
        .re  (rd_en),
        .ra  ({rbank, rd_addr}),
        .rd  (rdata)
    );

    // Null and idle samples are forced to zero rather than taken from the RAM.
    assign io = sel ? rdata[2*DW-1:DW] : '0;
    assign qo = sel ? rdata[DW-1:0]    : '0;

endmodule
